// File: rtl/timer_mc.sv
// timer_mc: multi-channel memory-mapped timer.
//
// One shared 64-bit mtime counter advanced by a programmable prescaler, plus
// NumChannels 64-bit comparators. Each comparator is one-shot or periodic
// (auto-reload by PERIOD) and sets a sticky bit in IRQ_STATUS. The level
// interrupt is the registered OR of IRQ_STATUS & IRQ_ENABLE.
//
// Optional feature macro: TIMER_MC_SNAPSHOT_EN. When defined, a read of
// MTIME_LO latches mtime[63:32] into a shadow register that MTIME_HI reads
// return, so a LO-then-HI read pair is coherent.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   timer_req_i     bus request (accepted every cycle)
//   timer_we_i      write enable
//   timer_be_i      byte enables
//   timer_addr_i    byte address (addr[9:2] decoded)
//   timer_wdata_i   write data
//   timer_rvalid_o  response valid, one cycle after the request
//   timer_rdata_o   read data (0 on writes and errors)
//   timer_err_o     error response for unmapped offsets
//   timer_intr_o    timer interrupt, level
module timer_mc #(
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned NumChannels    = 4,
   parameter int unsigned PrescalerWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    timer_req_i,
   input  logic                    timer_we_i,
   input  logic [DataWidth/8-1:0]  timer_be_i,
   input  logic [AddressWidth-1:0] timer_addr_i,
   input  logic [DataWidth-1:0]    timer_wdata_i,
   output logic                    timer_rvalid_o,
   output logic [DataWidth-1:0]    timer_rdata_o,
   output logic                    timer_err_o,
   output logic                    timer_intr_o
);

   localparam int unsigned BeWidth = DataWidth / 8;

   function automatic logic [DataWidth-1:0] apply_be(input logic [DataWidth-1:0] old_val,
                                                     input logic [DataWidth-1:0] new_val,
                                                     input logic [DataWidth-1:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [5:0]           glob_word;
   logic [3:0]           ch_sel;
   logic [1:0]           ch_reg;
   logic                 glob_ok, ch_ok, addr_ok;
   logic                 wr_en, rd_en;
   logic [DataWidth-1:0] be_mask;
   logic                 unused_addr;

   assign glob_word   = timer_addr_i[7:2];
   assign ch_sel      = timer_addr_i[7:4];
   assign ch_reg      = timer_addr_i[3:2];
   assign glob_ok     = (timer_addr_i[9:8] == 2'b00) && (glob_word <= 6'd4);
   assign ch_ok       = (timer_addr_i[9:8] == 2'b01) && ({28'd0, ch_sel} < NumChannels);
   assign addr_ok     = glob_ok | ch_ok;
   assign wr_en       = timer_req_i & timer_we_i & addr_ok;
   assign rd_en       = timer_req_i & ~timer_we_i & addr_ok;
   assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};

   always_comb begin
      be_mask = '0;
      for (int unsigned i = 0; i < BeWidth; i++) begin
         be_mask[8*i +: 8] = {8{timer_be_i[i]}};
      end
   end

   logic wr_mtime_lo, wr_mtime_hi, wr_prescale, wr_status, wr_enable, rd_mtime_lo;

   assign wr_mtime_lo = wr_en & glob_ok & (glob_word == 6'd0);
   assign wr_mtime_hi = wr_en & glob_ok & (glob_word == 6'd1);
   assign wr_prescale = wr_en & glob_ok & (glob_word == 6'd2);
   assign wr_status   = wr_en & glob_ok & (glob_word == 6'd3);
   assign wr_enable   = wr_en & glob_ok & (glob_word == 6'd4);
   assign rd_mtime_lo = rd_en & glob_ok & (glob_word == 6'd0);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [63:0]               mtime_q, mtime_d;
   logic [PrescalerWidth-1:0] prescale_q, prescale_d;
   logic [PrescalerWidth-1:0] prescale_cnt_q, prescale_cnt_d;
   logic [NumChannels-1:0]    irq_status_q, irq_status_d;
   logic [NumChannels-1:0]    irq_enable_q, irq_enable_d;
   logic [63:0]               cmp_q    [NumChannels];
   logic [63:0]               cmp_d    [NumChannels];
   logic [1:0]                ctrl_q   [NumChannels];  // bit0 EN, bit1 PERIODIC
   logic [1:0]                ctrl_d   [NumChannels];
   logic [31:0]               period_q [NumChannels];
   logic [31:0]               period_d [NumChannels];
   logic [NumChannels-1:0]    match;
   logic                      tick;

   assign tick = (prescale_cnt_q == prescale_q);

   always_comb begin
      // Prescaler and mtime; a bus write to either mtime half overrides the tick
      prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
      prescale_d     = prescale_q;
      if (wr_prescale) begin
         prescale_cnt_d = '0;
         prescale_d     = PrescalerWidth'(apply_be(DataWidth'(prescale_q), timer_wdata_i,
                                                   be_mask));
      end

      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr_mtime_lo) begin
         mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], timer_wdata_i, be_mask)};
      end else if (wr_mtime_hi) begin
         mtime_d = {apply_be(mtime_q[63:32], timer_wdata_i, be_mask), mtime_q[31:0]};
      end

      irq_enable_d = irq_enable_q;
      if (wr_enable) begin
         irq_enable_d = NumChannels'(apply_be(DataWidth'(irq_enable_q), timer_wdata_i, be_mask));
      end

      // Comparators: bus writes to CMP/CTRL win over hardware updates
      match = '0;
      for (int unsigned n = 0; n < NumChannels; n++) begin
         match[n]    = ctrl_q[n][0] & (mtime_q >= cmp_q[n]);
         cmp_d[n]    = cmp_q[n];
         ctrl_d[n]   = ctrl_q[n];
         period_d[n] = period_q[n];

         if (match[n]) begin
            if (ctrl_q[n][1]) begin
               cmp_d[n] = cmp_q[n] + {32'd0, period_q[n]};
            end else begin
               ctrl_d[n][0] = 1'b0;
            end
         end

         if (wr_en && ch_ok && (ch_sel == 4'(n))) begin
            unique case (ch_reg)
               2'd0: cmp_d[n] = {cmp_q[n][63:32], apply_be(cmp_q[n][31:0], timer_wdata_i, be_mask)};
               2'd1: cmp_d[n] = {apply_be(cmp_q[n][63:32], timer_wdata_i, be_mask), cmp_q[n][31:0]};
               2'd2: ctrl_d[n] = 2'(apply_be(DataWidth'(ctrl_q[n]), timer_wdata_i, be_mask));
               2'd3: period_d[n] = apply_be(period_q[n], timer_wdata_i, be_mask);
               default: ;
            endcase
         end
      end

      // Hardware set takes priority over a coincident W1C
      irq_status_d = irq_status_q;
      if (wr_status) begin
         irq_status_d = irq_status_q & ~NumChannels'(timer_wdata_i & be_mask);
      end
      irq_status_d = irq_status_d | match;
   end

   // ---------------------------------------------------------------------------
   // MTIME_HI read source
   // ---------------------------------------------------------------------------
   logic [31:0] mtime_hi_rd;

`ifdef TIMER_MC_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (rd_mtime_lo) begin
         shadow_d = mtime_q[63:32];
      end else if (wr_mtime_hi) begin
         shadow_d = mtime_d[63:32];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign mtime_hi_rd = shadow_q;
`else
   logic unused_rd_lo;
   assign unused_rd_lo = rd_mtime_lo;
   assign mtime_hi_rd  = mtime_q[63:32];
`endif

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   logic [DataWidth-1:0] rd_val;

   always_comb begin
      rd_val = '0;
      if (glob_ok) begin
         unique case (glob_word[2:0])
            3'd0:    rd_val = mtime_q[31:0];
            3'd1:    rd_val = mtime_hi_rd;
            3'd2:    rd_val = DataWidth'(prescale_q);
            3'd3:    rd_val = DataWidth'(irq_status_q);
            3'd4:    rd_val = DataWidth'(irq_enable_q);
            default: rd_val = '0;
         endcase
      end else if (ch_ok) begin
         for (int unsigned n = 0; n < NumChannels; n++) begin
            if (ch_sel == 4'(n)) begin
               unique case (ch_reg)
                  2'd0: rd_val = cmp_q[n][31:0];
                  2'd1: rd_val = cmp_q[n][63:32];
                  2'd2: rd_val = DataWidth'(ctrl_q[n]);
                  2'd3: rd_val = period_q[n];
                  default: ;
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_q        <= '0;
         prescale_q     <= '0;
         prescale_cnt_q <= '0;
         irq_status_q   <= '0;
         irq_enable_q   <= '0;
         for (int unsigned n = 0; n < NumChannels; n++) begin
            cmp_q[n]    <= '1;
            ctrl_q[n]   <= '0;
            period_q[n] <= '0;
         end
         timer_rvalid_o <= 1'b0;
         timer_rdata_o  <= '0;
         timer_err_o    <= 1'b0;
         timer_intr_o   <= 1'b0;
      end else begin
         mtime_q        <= mtime_d;
         prescale_q     <= prescale_d;
         prescale_cnt_q <= prescale_cnt_d;
         irq_status_q   <= irq_status_d;
         irq_enable_q   <= irq_enable_d;
         for (int unsigned n = 0; n < NumChannels; n++) begin
            cmp_q[n]    <= cmp_d[n];
            ctrl_q[n]   <= ctrl_d[n];
            period_q[n] <= period_d[n];
         end
         timer_rvalid_o <= timer_req_i;
         timer_rdata_o  <= rd_en ? rd_val : '0;
         timer_err_o    <= timer_req_i & ~addr_ok;
         timer_intr_o   <= |(irq_status_q & irq_enable_q);
      end
   end

endmodule

// File: tb/tb_timer_mc.sv
module tb_timer_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        rvalid, err, intr;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   timer_mc #(
      .DataWidth     (32),
      .AddressWidth  (32),
      .NumChannels   (4),
      .PrescalerWidth(16)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .timer_req_i   (req),
      .timer_we_i    (we),
      .timer_be_i    (be),
      .timer_addr_i  (addr),
      .timer_wdata_i (wdata),
      .timer_rvalid_o(rvalid),
      .timer_rdata_o (rdata),
      .timer_err_o   (err),
      .timer_intr_o  (intr)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } resp_t;

   resp_t sb_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    t0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus transaction; the expected response is queued at issue and popped on rvalid.
   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                      input string tag);
      resp_t r;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      sb_q.push_back('{data: exp_d, err: exp_e});
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0;
      check({tag, "_rvalid"}, rvalid, 1);
      r = sb_q.pop_front();
      if (rvalid === 1'b1) begin
         check({tag, "_rdata"}, rdata, r.data);
         check({tag, "_err"}, err, r.err);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
      bus(1'b1, a, d, 4'hF, 32'h0, 1'b0, tag);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus(1'b0, a, 32'h0, 4'hF, exp, 1'b0, tag);
   endtask

   // Poll for intr high with a bound; compare arrival cycle against t_start + delta.
   task automatic wait_intr(input int t_start, input int delta, input string tag);
      int n = 0;
      while (intr !== 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 64'(cyc - t_start), 64'(delta));
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_intr", intr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      rd(32'h100, 32'hFFFF_FFFF, "cmp0_lo_rst");
      @(posedge clk);
      #1;
      check("rvalid_one_cycle", rvalid, 0);
      rd(32'h104, 32'hFFFF_FFFF, "cmp0_hi_rst");
      rd(32'h00C, 32'h0, "status_rst");
      check("intr_after_rst", intr, 0);

      // Prescaler: PRESCALE=3 gives one tick per 4 cycles
      wr(32'h008, 32'd3, "wr_prescale3");
      wr(32'h000, 32'd0, "wr_mtime0");
      repeat (40) @(posedge clk);
      rd(32'h000, 32'd10, "mtime_prescaled");
      rd(32'h008, 32'd3, "prescale_rd");
      check("intr_idle", intr, 0);

      // Channel 0 one-shot at mtime 20
      wr(32'h100, 32'd20, "cmp0_lo");
      wr(32'h104, 32'd0, "cmp0_hi");
      wr(32'h010, 32'h1, "irq_en1");
      wr(32'h008, 32'd0, "prescale0");
      wr(32'h000, 32'd0, "mtime0_a");
      wr(32'h108, 32'h1, "ctrl0_en");
      t0 = cyc;
      wait_intr(t0, 21, "oneshot_intr_cycle");
      rd(32'h108, 32'h0, "ctrl0_cleared");
      rd(32'h00C, 32'h1, "status_oneshot");
      wr(32'h00C, 32'h1, "w1c0");
      check("intr_before_fall", intr, 1);
      @(posedge clk);
      #1;
      check("intr_fall", intr, 0);

      // W1C in the same cycle as a one-shot match: set wins
      wr(32'h100, 32'd1, "cmp0_lo_1");
      wr(32'h000, 32'd0, "mtime0_b");
      wr(32'h108, 32'h1, "ctrl0_en_b");
      wr(32'h00C, 32'h1, "w1c_collide");
      rd(32'h00C, 32'h1, "status_set_wins");
      wr(32'h00C, 32'h1, "w1c_plain");
      rd(32'h00C, 32'h0, "status_cleared");

      // Channel 1 periodic: matches at 100, 150, 200
      wr(32'h110, 32'd100, "cmp1_lo");
      wr(32'h114, 32'd0, "cmp1_hi");
      wr(32'h11C, 32'd50, "period1");
      wr(32'h010, 32'h2, "irq_en2");
      wr(32'h000, 32'd0, "mtime0_c");
      wr(32'h118, 32'h3, "ctrl1_periodic");
      t0 = cyc;
      wait_intr(t0, 101, "periodic_match100");
      wr(32'h00C, 32'h2, "w1c1_a");
      @(posedge clk);
      #1;
      check("intr_low_a", intr, 0);
      wait_intr(t0, 151, "periodic_match150");
      wr(32'h00C, 32'h2, "w1c1_b");
      @(posedge clk);
      #1;
      check("intr_low_b", intr, 0);
      wait_intr(t0, 201, "periodic_match200");
      rd(32'h110, 32'd250, "cmp1_reload");
      wr(32'h118, 32'h0, "ctrl1_off");
      wr(32'h00C, 32'h2, "w1c1_c");

      // Errors and byte enables
      bus(1'b0, 32'h3F0, 32'h0, 4'hF, 32'h0, 1'b1, "rd_unmapped");
      bus(1'b0, 32'h014, 32'h0, 4'hF, 32'h0, 1'b1, "rd_gap");
      bus(1'b1, 32'h148, 32'h3, 4'hF, 32'h0, 1'b1, "wr_bad_channel");
      rd(32'h108, 32'h0, "ctrl0_untouched");
      rd(32'h138, 32'h0, "ctrl3_valid");
      wr(32'h008, 32'hFFFF_FFFF, "prescale_max");
      rd(32'h008, 32'h0000_FFFF, "prescale_width");
      wr(32'h000, 32'h1234_5678, "mtime_lo_full");
      bus(1'b1, 32'h000, 32'hFFFF_FFAB, 4'b0001, 32'h0, 1'b0, "mtime_lo_byte0");
      rd(32'h000, 32'h1234_56AB, "mtime_be_result");

      // Carry across the 32-bit boundary
      wr(32'h008, 32'd0, "prescale0_b");
      wr(32'h004, 32'd0, "mtime_hi0");
      wr(32'h000, 32'hFFFF_FFFF, "mtime_lo_max");
      rd(32'h000, 32'hFFFF_FFFF, "carry_lo");
`ifdef TIMER_MC_SNAPSHOT_EN
      rd(32'h004, 32'd0, "carry_hi_snapshot");
`else
      rd(32'h004, 32'd1, "carry_hi_live");
`endif

      // Interrupt pending, then reset during a request
      wr(32'h100, 32'd0, "cmp0_lo_0");
      wr(32'h104, 32'd0, "cmp0_hi_0");
      wr(32'h010, 32'h1, "irq_en1_b");
      wr(32'h108, 32'h1, "ctrl0_en_c");
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_intr", intr, 1);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h100; be = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_intr", intr, 0);
      @(posedge clk);
      #1;
      check("rst_drops_rvalid", rvalid, 0);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(32'h100, 32'hFFFF_FFFF, "cmp0_after_rst");
      rd(32'h00C, 32'h0, "status_after_rst");
      rd(32'h108, 32'h0, "ctrl0_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
